// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the kitchen-timer sequencer: state encodings and
// alarm counter sizing.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SET   = 2'b01,
    ST_RUN   = 2'b10,
    ST_ALARM = 2'b11
  } state_e;

  localparam int ALARM_CNT_W   = 8;
  localparam int ALARM_SECS_MAX = (1 << ALARM_CNT_W) - 1;

  function automatic logic alarm_secs_legal(input int secs);
    return (secs >= 1) && (secs <= ALARM_SECS_MAX);
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Strobe/status bundle between the sequencer and the mm:ss BCD counter chain.
interface timer_ctrl_if;

  logic cnt_dec;
  logic cnt_inc_min;
  logic cnt_inc_sec;
  logic cnt_clr;
  logic cnt_zero;

  modport master (
    output cnt_dec,
    output cnt_inc_min,
    output cnt_inc_sec,
    output cnt_clr,
    input  cnt_zero
  );

  modport slave (
    input  cnt_dec,
    input  cnt_inc_min,
    input  cnt_inc_sec,
    input  cnt_clr,
    output cnt_zero
  );

endinterface

// File: rtl/timer_ctrl_edge_pulse.sv
// Rising-edge detector for a debounced button level. The first cycle after
// reset only captures history, so a button held through reset gives no edge.
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      armed_q <= 1'b1;
    end
  end

  assign pulse_o = level_i & ~prev_q & armed_q;

endmodule

// File: rtl/timer_ctrl.sv
// Kitchen-timer sequencer: converts button edges, set-mode and the 1 s tick
// into registered strobes for the counter chain, plus run/alarm/blink status.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int ALARM_SECS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1s,
  input  logic               btn_ss,
  input  logic               btn_min,
  input  logic               btn_sec,
  input  logic               set_mode,
  timer_ctrl_if.master       chain,
  output logic               running,
  output logic               alarm,
  output logic               blink,
  output logic [1:0]         state
);

  if (!alarm_secs_legal(ALARM_SECS)) begin : g_bad_alarm_secs
    $error("timer_ctrl: ALARM_SECS must be in 1..255");
  end

  localparam logic [ALARM_CNT_W-1:0] ALARM_LOAD = ALARM_CNT_W'(ALARM_SECS);

  logic ev_ss, ev_min, ev_sec, ev_any;

  edge_pulse u_edge_ss (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (btn_ss),
    .pulse_o (ev_ss)
  );

  edge_pulse u_edge_min (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (btn_min),
    .pulse_o (ev_min)
  );

  edge_pulse u_edge_sec (
    .clk     (clk),
    .rst_n   (rst_n),
    .level_i (btn_sec),
    .pulse_o (ev_sec)
  );

  assign ev_any = ev_ss | ev_min | ev_sec;

  state_e                 state_q, state_d;
  logic [ALARM_CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
  logic                   blink_q, blink_d;
  logic                   dec_q, dec_d;
  logic                   inc_min_q, inc_min_d;
  logic                   inc_sec_q, inc_sec_d;
  logic                   clr_q, clr_d;
  logic                   running_q, running_d;
  logic                   alarm_q, alarm_d;

  always_comb begin
    state_d     = state_q;
    alarm_cnt_d = alarm_cnt_q;
    blink_d     = blink_q;
    dec_d       = 1'b0;
    inc_min_d   = 1'b0;
    inc_sec_d   = 1'b0;
    clr_d       = 1'b0;

    // set_mode overrides everything; edges only strobe once already in SET.
    if (set_mode) begin
      state_d = ST_SET;
      if (state_q == ST_SET) begin
        inc_min_d = ev_min;
        inc_sec_d = ev_sec;
        clr_d     = ev_ss;
      end
    end else begin
      unique case (state_q)
        ST_SET: state_d = ST_IDLE;
        ST_IDLE: begin
          if (ev_ss && !chain.cnt_zero) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (chain.cnt_zero) begin
            state_d     = ST_ALARM;
            alarm_cnt_d = ALARM_LOAD;
            blink_d     = 1'b1;
          end else if (ev_ss) begin
            state_d = ST_IDLE;
          end else if (tick_1s) begin
            dec_d = 1'b1;
          end
        end
        ST_ALARM: begin
          if (ev_any) begin
            state_d = ST_IDLE;
          end else if (tick_1s) begin
            alarm_cnt_d = alarm_cnt_q - 1'b1;
            blink_d     = ~blink_q;
            if (alarm_cnt_q == ALARM_CNT_W'(1)) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Alarm bookkeeping is meaningless outside ALARM; park it at zero.
    if (state_d != ST_ALARM) begin
      blink_d     = 1'b0;
      alarm_cnt_d = '0;
    end

    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alarm_cnt_q <= '0;
      blink_q     <= 1'b0;
      dec_q       <= 1'b0;
      inc_min_q   <= 1'b0;
      inc_sec_q   <= 1'b0;
      clr_q       <= 1'b0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarm_cnt_q <= alarm_cnt_d;
      blink_q     <= blink_d;
      dec_q       <= dec_d;
      inc_min_q   <= inc_min_d;
      inc_sec_q   <= inc_sec_d;
      clr_q       <= clr_d;
      running_q   <= running_d;
      alarm_q     <= alarm_d;
    end
  end

  assign chain.cnt_dec     = dec_q;
  assign chain.cnt_inc_min = inc_min_q;
  assign chain.cnt_inc_sec = inc_sec_q;
  assign chain.cnt_clr     = clr_q;
  assign running           = running_q;
  assign alarm             = alarm_q;
  assign blink             = blink_q;
  assign state             = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: directed scenarios then random stimulus,
// expected outputs from an event-level reference model.
module tb_timer_ctrl;

  localparam int ALARM_SECS = 3;

  logic       clk = 1'b0;
  logic       rst_n, tick_1s, btn_ss, btn_min, btn_sec, set_mode;
  logic       running, alarm, blink;
  logic [1:0] state;

  timer_ctrl_if chain_if ();

  timer_ctrl #(.ALARM_SECS(ALARM_SECS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1s  (tick_1s),
    .btn_ss   (btn_ss),
    .btn_min  (btn_min),
    .btn_sec  (btn_sec),
    .set_mode (set_mode),
    .chain    (chain_if.master),
    .running  (running),
    .alarm    (alarm),
    .blink    (blink),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Expected vector: {state[1:0], running, alarm, blink, dec, inc_min, inc_sec, clr}
  logic [8:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_SET, M_RUN, M_ALARM} mode_t;
  mode_t m_mode;
  int    m_left;
  bit    m_blink;
  bit    m_fresh;           // first clk after reset: history only
  bit    p_ss, p_min, p_sec;

  function automatic logic [1:0] mode_code(mode_t m);
    case (m)
      M_SET:   return 2'b01;
      M_RUN:   return 2'b10;
      M_ALARM: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_step();
    bit e_ss, e_min, e_sec, dec, imin, isec, clr;
    dec = 0; imin = 0; isec = 0; clr = 0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_left = 0; m_blink = 0; m_fresh = 1;
      p_ss = 0; p_min = 0; p_sec = 0;
    end else begin
      e_ss  = !m_fresh && btn_ss  && !p_ss;
      e_min = !m_fresh && btn_min && !p_min;
      e_sec = !m_fresh && btn_sec && !p_sec;
      p_ss = btn_ss; p_min = btn_min; p_sec = btn_sec; m_fresh = 0;
      if (set_mode) begin
        if (m_mode == M_SET) begin imin = e_min; isec = e_sec; clr = e_ss; end
        m_mode = M_SET;
      end else begin
        case (m_mode)
          M_SET:  m_mode = M_IDLE;
          M_IDLE: if (e_ss && !chain_if.cnt_zero) m_mode = M_RUN;
          M_RUN: begin
            if (chain_if.cnt_zero) begin
              m_mode = M_ALARM; m_left = ALARM_SECS; m_blink = 1;
            end else if (e_ss) m_mode = M_IDLE;
            else if (tick_1s) dec = 1;
          end
          M_ALARM: begin
            if (e_ss || e_min || e_sec) m_mode = M_IDLE;
            else if (tick_1s) begin
              m_left--; m_blink = !m_blink;
              if (m_left == 0) m_mode = M_IDLE;
            end
          end
        endcase
      end
      if (m_mode != M_ALARM) m_blink = 0;
    end
    exp_q.push_back({mode_code(m_mode), m_mode == M_RUN, m_mode == M_ALARM,
                     m_blink, dec, imin, isec, clr});
  endtask

  // Apply one clk worth of inputs at the negedge, then advance the model.
  task automatic cyc(input bit r, input bit ss, input bit mn, input bit sc,
                     input bit sm, input bit tk, input bit zr);
    @(negedge clk);
    rst_n = r; btn_ss = ss; btn_min = mn; btn_sec = sc;
    set_mode = sm; tick_1s = tk; chain_if.cnt_zero = zr;
    model_step();
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [8:0] act, e;
    forever begin
      @(posedge clk);
      #1;
      act = {state, running, alarm, blink, chain_if.cnt_dec, chain_if.cnt_inc_min,
             chain_if.cnt_inc_sec, chain_if.cnt_clr};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_underflow t=%0t actual=%b required=<queued entry>", $time, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL outputs t=%0t {st,run,alm,blk,dec,imin,isec,clr} actual=%b required=%b",
                   $time, act, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit ss, mn, sc, sm, zr, rr;
    rst_n = 0; btn_ss = 1; btn_min = 0; btn_sec = 0;
    set_mode = 0; tick_1s = 0; chain_if.cnt_zero = 0;
    model_step();

    // Reset with btn_ss held, then release: must stay IDLE.
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);

    // Start, three ticks, pause coincident with a tick.
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3) begin
      cyc(1, 0, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
    end
    cyc(1, 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // IDLE with zero count: start ignored.
    cyc(1, 1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);

    // Run into zero -> ALARM, three ticks return to IDLE.
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 1, 1);
    repeat (3) begin
      cyc(1, 0, 0, 0, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 1, 1);
    end
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 1);

    // ALARM cancelled by btn_min; then final tick coincident with a button.
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // set_mode aborts RUN; adjust, clear, leave.
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 1, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    ss = 0; mn = 0; sc = 0; sm = 0; zr = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) ss = !ss;
      if ($urandom_range(0, 7) == 0) mn = !mn;
      if ($urandom_range(0, 7) == 0) sc = !sc;
      if ($urandom_range(0, 60) == 0) sm = !sm;
      if ($urandom_range(0, 9) == 0) zr = !zr;
      rr = ($urandom_range(0, 400) != 0);
      cyc(rr, ss, mn, sc, sm, $urandom_range(0, 3) == 0, zr);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d left required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
